// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_reader_pkg
//   Shared definitions for the memory stream reader slice.
//   Contents:
//     state_t                  2-bit sequencer state encoding
//     ST_IDLE/RUN/DRAIN/FINISH sequencer states (legacy-compatible constants)
package mem_stream_reader_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if
//   Bundles the control, memory-side and stream-side signals of the reader.
//   Signals:
//     start, base_addr, length   transfer request (sampled when idle)
//     busy, done                 transfer status
//     mem_addr, mem_q            synchronous-read memory port (1-cycle latency)
//     out_data, out_valid,
//     out_ready, out_last        valid/ready output stream
//   Modports:
//     master   the reader itself
//     slave    the surrounding environment (requester, memory, consumer)
interface mem_stream_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_q;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  start, base_addr, length, mem_q, out_ready,
        output busy, done, mem_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, length, mem_q, out_ready,
        input  busy, done, mem_addr, out_data, out_valid, out_last
    );

endinterface

// File: rtl/mem_stream_reader_fifo_skid2.sv
// fifo_skid2
//   Two-entry register FIFO holding {last, data}. Absorbs the words that are
//   already in flight from the memory when the stream consumer stalls.
//   Simultaneous push and pop is legal when empty or full.
//   Ports:
//     clock, rst_n         clock, asynchronous active-low reset
//     push_i, pushData_i,
//     pushLast_i           write one entry
//     pop_i                remove head entry (ignored when empty)
//     data_o, last_o       head entry
//     count_o              number of stored entries (0..2)
module fifo_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pushLast_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    logic [WIDTH:0] ent0_q, ent0_d;
    logic [WIDTH:0] ent1_q, ent1_d;
    logic [1:0]     count_q, count_d;
    logic           doPop;
    logic [1:0]     slot;

    // Pop shifts entry 1 into the head; a push then lands in the first free
    // slot after that shift, so push+pop on a full FIFO keeps order intact.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        doPop   = pop_i && (count_q != 2'd0);
        slot    = count_q;
        if (doPop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
            slot    = count_q - 2'd1;
        end
        if (push_i) begin
            if (slot == 2'd0) begin
                ent0_d = {pushLast_i, pushData_i};
            end else begin
                ent1_d = {pushLast_i, pushData_i};
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    // The issue rule upstream guarantees a free slot for every in-flight word.
    always_ff @(posedge clock) begin
        if (rst_n) begin
            assert (!(push_i && !doPop && count_q == 2'd2));
        end
    end

    assign data_o  = ent0_q[WIDTH-1:0];
    assign last_o  = ent0_q[WIDTH];
    assign count_o = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
//   Read-side sequencer for a synchronous-read memory port. On start it walks
//   length consecutive addresses from base_addr (wrapping at DEPTH), absorbs the
//   one-cycle read latency in a 2-entry skid FIFO and presents the words on a
//   valid/ready stream with full backpressure. Never writes the memory.
//   Ports:
//     clock   single clock, all logic on posedge
//     rst_n   asynchronous active-low reset
//     bus     mem_stream_reader_if.master (request, status, memory, stream)
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input logic                 clock,
    input logic                 rst_n,
    mem_stream_reader_if.master bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  issueRem_q, issueRem_d;
    logic              inflight_q;
    logic              inflightLast_q;
    logic              issue;
    logic              handshake;
    logic              fifoValid;
    logic              headLast;
    logic [1:0]        fifoCount;
    logic [WIDTH-1:0]  headData;
    logic [ADDR_W-1:0] nextAddr;

    // Explicit wrap compare so non-power-of-two depths work.
    assign nextAddr = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    assign fifoValid = (fifoCount != 2'd0);
    assign handshake = fifoValid && bus.out_ready;

    // Only issue when the word that comes back has a guaranteed FIFO slot:
    // either the FIFO plus the in-flight word leave room, or a word leaves
    // the FIFO this very cycle.
    assign issue = (state_q == ST_RUN) &&
                   ((({1'b0, fifoCount} + {2'b00, inflight_q}) < 3'd2) || handshake);

    // Sequencer: load the request when idle, step through addresses while
    // running, wait for the tagged last word to leave, then pulse done.
    // The address is not advanced on the final issue so mem_addr rests on
    // the last address read.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issueRem_d = issueRem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d     = bus.base_addr;
                    issueRem_d = bus.length;
                    state_d    = (bus.length == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issueRem_d = issueRem_q - LEN_W'(1);
                    if (issueRem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = nextAddr;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake && headLast) begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and remaining-count registers, plus the in-flight flag
    // that marks mem_q as valid (and possibly last) in the following cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            issueRem_q     <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issueRem_q     <= issueRem_d;
            inflight_q     <= issue;
            inflightLast_q <= issue && (issueRem_q == LEN_W'(1));
        end
    end

    fifo_skid2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock      (clock),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .pushData_i (bus.mem_q),
        .pushLast_i (inflightLast_q),
        .pop_i      (handshake),
        .data_o     (headData),
        .last_o     (headLast),
        .count_o    (fifoCount)
    );

    assign bus.mem_addr  = addr_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FINISH);
    assign bus.out_valid = fifoValid;
    assign bus.out_data  = headData;
    assign bus.out_last  = fifoValid && headLast;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader
//   Directed, table-driven bench for mem_stream_reader with a behavioural
//   64x8 synchronous-read memory preloaded with mem[i] = i.
module tb_mem_stream_reader;

    logic clock;
    logic rst_n;

    mem_stream_reader_if #(.WIDTH(8), .DEPTH(64)) bus ();

    mem_stream_reader #(
        .WIDTH (8),
        .DEPTH (64)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation, 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: one-cycle synchronous read, never written.
    logic [7:0] mem [64];
    always @(posedge clock) bus.mem_q <= mem[bus.mem_addr];

    typedef struct {
        logic [5:0]      base;
        logic [6:0]      len;
        int              mode;
        bit              poke;
        int              expDone;
        logic [7:0][7:0] expWords;
    } vec_t;

    vec_t vecs [8];
    bit   readyPat [4];

    int   vecCount;
    int   missCount;

    int         gotWords [$];
    bit         gotLast  [$];
    int         addrSeq  [$];
    int         doneAt;
    int         busyCycles;
    int         stallErr;
    int         firstValid;
    bit         seenDone;

    // One comparison: counts it, and reports it when actual differs.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Runs one transfer: pulses start, drives out_ready per mode (0 = always
    // ready, 1 = pattern 1,0,0,1), optionally pokes start mid-transfer, and
    // records words, last flags, addresses, timing and stall violations.
    task automatic applyStimulus(input logic [5:0] base, input logic [6:0] len, input int mode, input bit poke);
        bit         prevStall;
        logic [7:0] prevData;
        logic       prevLast;
        gotWords.delete();
        gotLast.delete();
        addrSeq.delete();
        doneAt     = -1;
        busyCycles = 0;
        stallErr   = 0;
        firstValid = -1;
        seenDone   = 1'b0;
        prevStall  = 1'b0;
        prevData   = 8'd0;
        prevLast   = 1'b0;
        @(negedge clock);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 400 && !seenDone; cyc++) begin
            @(negedge clock);
            bus.start = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                bus.base_addr = 6'd33;
                bus.length    = 7'd3;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : readyPat[(cyc - 1) % 4];
            if (prevStall && (bus.out_valid !== 1'b1 || bus.out_data !== prevData || bus.out_last !== prevLast))
                stallErr++;
            if (dut.u_fifo.count_q > 2'd2)
                stallErr++;
            if (bus.busy === 1'b1) begin
                busyCycles++;
                if (addrSeq.size() == 0 || addrSeq[$] != int'(bus.mem_addr))
                    addrSeq.push_back(int'(bus.mem_addr));
            end
            if (bus.out_valid === 1'b1 && firstValid < 0)
                firstValid = cyc;
            if (bus.done === 1'b1) begin
                doneAt   = cyc;
                seenDone = 1'b1;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                gotWords.push_back(int'(bus.out_data));
                gotLast.push_back(bus.out_last);
            end
            prevStall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        readyPat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);

        vecs[0] = '{base: 6'd0,  len: 7'd4, mode: 0, poke: 1'b0, expDone: 7, expWords: 64'h00000000_03020100};
        vecs[1] = '{base: 6'd62, len: 7'd4, mode: 0, poke: 1'b0, expDone: 7, expWords: 64'h00000000_01003f3e};
        vecs[2] = '{base: 6'd10, len: 7'd1, mode: 0, poke: 1'b0, expDone: 4, expWords: 64'h00000000_0000000a};
        vecs[3] = '{base: 6'd0,  len: 7'd8, mode: 1, poke: 1'b0, expDone: 0, expWords: 64'h07060504_03020100};
        vecs[4] = '{base: 6'd60, len: 7'd8, mode: 1, poke: 1'b0, expDone: 0, expWords: 64'h03020100_3f3e3d3c};
        vecs[5] = '{base: 6'd63, len: 7'd2, mode: 0, poke: 1'b0, expDone: 5, expWords: 64'h00000000_0000003f};
        vecs[6] = '{base: 6'd20, len: 7'd0, mode: 0, poke: 1'b0, expDone: 1, expWords: 64'h0};
        vecs[7] = '{base: 6'd5,  len: 7'd3, mode: 0, poke: 1'b1, expDone: 6, expWords: 64'h00000000_00070605};

        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        checkOutput("reset busy",      32'(bus.busy),      32'd0);
        checkOutput("reset done",      32'(bus.done),      32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_last",  32'(bus.out_last),  32'd0);
        checkOutput("reset mem_addr",  32'(bus.mem_addr),  32'd0);
        checkOutput("reset out_data",  32'(bus.out_data),  32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        // Table-driven transfers.
        for (int v = 0; v < 8; v++) begin
            int lastErr;
            applyStimulus(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].poke);
            checkOutput($sformatf("v%0d done seen", v), 32'(seenDone), 32'd1);
            if (vecs[v].expDone > 0)
                checkOutput($sformatf("v%0d done cycle", v), 32'(doneAt), 32'(vecs[v].expDone));
            checkOutput($sformatf("v%0d busy cycles", v), 32'(busyCycles), 32'(doneAt));
            if (vecs[v].len == 7'd0) begin
                checkOutput($sformatf("v%0d no valid", v), 32'(firstValid), 32'hffff_ffff);
            end else begin
                if (vecs[v].mode == 0)
                    checkOutput($sformatf("v%0d first valid", v), 32'(firstValid), 32'd3);
                checkOutput($sformatf("v%0d addr count", v), 32'(addrSeq.size()), 32'(vecs[v].len));
                for (int k = 0; k < int'(vecs[v].len) && k < addrSeq.size(); k++)
                    checkOutput($sformatf("v%0d addr%0d", v, k), 32'(addrSeq[k]), 32'(vecs[v].expWords[k]));
            end
            checkOutput($sformatf("v%0d word count", v), 32'(gotWords.size()), 32'(vecs[v].len));
            lastErr = 0;
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                checkOutput($sformatf("v%0d word%0d", v, k),
                            (k < gotWords.size()) ? 32'(gotWords[k]) : 32'hffff_ffff,
                            32'(vecs[v].expWords[k]));
                if (k < gotLast.size() && gotLast[k] != (k == int'(vecs[v].len) - 1))
                    lastErr++;
            end
            checkOutput($sformatf("v%0d last flags", v), 32'(lastErr), 32'd0);
            checkOutput($sformatf("v%0d stall/fifo", v), 32'(stallErr), 32'd0);
            @(negedge clock);
            checkOutput($sformatf("v%0d done is a pulse", v), 32'(bus.done), 32'd0);
            checkOutput($sformatf("v%0d idle after", v), 32'(bus.busy), 32'd0);
        end

        // Full-depth transfer from a non-zero base reads every word once.
        applyStimulus(6'd5, 7'd64, 0, 1'b0);
        checkOutput("full done cycle", 32'(doneAt), 32'd67);
        checkOutput("full word count", 32'(gotWords.size()), 32'd64);
        begin
            int wordErr;
            wordErr = 0;
            for (int k = 0; k < 64 && k < gotWords.size(); k++)
                if (gotWords[k] != (5 + k) % 64) wordErr++;
            checkOutput("full word order", 32'(wordErr), 32'd0);
        end
        checkOutput("full last on final", 32'(gotLast.size() == 64 ? gotLast[63] : 1'b0), 32'd1);

        // Reset in the middle of a transfer, while word 3 is presented.
        @(negedge clock);
        bus.start     = 1'b1;
        bus.base_addr = 6'd0;
        bus.length    = 7'd8;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("pre-reset valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre-reset data",  32'(bus.out_data),  32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-reset busy",      32'(bus.busy),      32'd0);
        checkOutput("mid-reset done",      32'(bus.done),      32'd0);
        checkOutput("mid-reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid-reset out_last",  32'(bus.out_last),  32'd0);
        checkOutput("mid-reset mem_addr",  32'(bus.mem_addr),  32'd0);
        checkOutput("mid-reset out_data",  32'(bus.out_data),  32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("post-reset no done", 32'(bus.done), 32'd0);
        checkOutput("post-reset idle",    32'(bus.busy), 32'd0);

        // A fresh transfer after the reset behaves normally.
        applyStimulus(6'd20, 7'd3, 0, 1'b0);
        checkOutput("fresh done cycle", 32'(doneAt), 32'd6);
        checkOutput("fresh word count", 32'(gotWords.size()), 32'd3);
        checkOutput("fresh word0", gotWords.size() > 0 ? 32'(gotWords[0]) : 32'hffff_ffff, 32'd20);
        checkOutput("fresh word2", gotWords.size() > 2 ? 32'(gotWords[2]) : 32'hffff_ffff, 32'd22);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
